// File: rtl/slicem_srl.sv
// slicem_srl: memory slice of NUM_LUTS dual-output LUTs, each configured as ROM, RAM or SRL.
// Latency: out/wide_out/srl_q are combinational from storage; config, writes and shifts show next cycle; sync_out lags out by one.
// Backpressure: none; cen/write_en/shift_en/reg_ce act in the cycle they are sampled.
//
// Ports:
//   clk, rst          single clock for config, memory and registers; synchronous active-high reset
//   cen, config_in    serial config shift (first bit in lands at the MSB); config_out = chain MSB
//   luts_in           per-LUT {addrB, addrA}, LUT i at [2K*i +: 2K]
//   higher_order_addr LUT select for RAM writes and wide_out
//   data_in           RAM write data / SRL serial input
//   write_en, write_lut_select  RAM write strobe and half select (addrA addresses both halves)
//   shift_en          SRL shift strobe
//   reg_ce            sync_out capture enable
//   out, wide_out     async reads; wide_out = out[2*higher_order_addr]
//   srl_q             top bit of the last LUT's shift vector
//   sync_out          registered copy of out
//
// Optional feature: define SLICEM_SRL_CASCADE_EN to chain each SRL LUT into the next one
// when both are in SRL mode. Without it every SRL LUT shifts data_in and srl_q is 0.

module slicem_srl #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int LUT_W     = 2*2**S_XX_BASE+2,
  parameter int CFG_LEN   = NUM_LUTS*LUT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cen,
  input  logic                            config_in,
  output logic                            config_out,
  input  logic [2*S_XX_BASE*NUM_LUTS-1:0] luts_in,
  input  logic [MUX_LVLS-1:0]             higher_order_addr,
  input  logic                            data_in,
  input  logic                            write_en,
  input  logic                            write_lut_select,
  input  logic                            shift_en,
  input  logic                            reg_ce,
  output logic [2*NUM_LUTS-1:0]           out,
  output logic                            wide_out,
  output logic                            srl_q,
  output logic [2*NUM_LUTS-1:0]           sync_out
);

  localparam int K    = S_XX_BASE;
  localparam int HALF = 2**K;
  localparam int VEC  = 2*HALF;

  localparam logic [1:0] MODE_RAM = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;

  logic [CFG_LEN-1:0]  chain;
  logic [CFG_LEN-1:0]  chain_nxt;
  logic [1:0]          mode   [NUM_LUTS];
  logic [VEC-1:0]      vec    [NUM_LUTS];
  logic [K-1:0]        addr_a [NUM_LUTS];
  logic [K-1:0]        addr_b [NUM_LUTS];
  logic [NUM_LUTS-1:0] cin;
  logic [VEC-1:0]      vec_nxt;

  // Per-LUT views of the config chain. half0 is the low half of vec, so
  // half0[a] = vec[{0,a}] and half1[b] = vec[{1,b}].
  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    assign mode[g]    = chain[g*LUT_W +: 2];
    assign vec[g]     = chain[g*LUT_W+2 +: VEC];
    assign addr_a[g]  = luts_in[2*K*g +: K];
    assign addr_b[g]  = luts_in[2*K*g+K +: K];
    assign out[2*g]   = vec[g][{1'b0, addr_a[g]}];
    assign out[2*g+1] = vec[g][{1'b1, addr_b[g]}];

    if (g == 0) begin : g_cin_first
      assign cin[g] = data_in;
    end else begin : g_cin_rest
`ifdef SLICEM_SRL_CASCADE_EN
      // Cascade only when the lower neighbour is also a shift register.
      assign cin[g] = (mode[g-1] == MODE_SRL) ? vec[g-1][VEC-1] : data_in;
`else
      assign cin[g] = data_in;
`endif
    end
  end

  assign config_out = chain[CFG_LEN-1];
  assign wide_out   = out[{higher_order_addr, 1'b0}];

`ifdef SLICEM_SRL_CASCADE_EN
  assign srl_q = vec[NUM_LUTS-1][VEC-1];
`else
  assign srl_q = 1'b0;
`endif

  // Config shifting masks writes and shifts. Otherwise each LUT updates from
  // pre-shift values; a LUT is in exactly one mode, so a write and a shift
  // never touch the same LUT.
  always_comb begin
    chain_nxt = chain;
    vec_nxt   = '0;
    if (cen) begin
      chain_nxt = {chain[CFG_LEN-2:0], config_in};
    end else begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        vec_nxt = vec[i];
        if (shift_en && mode[i] == MODE_SRL) begin
          vec_nxt = {vec[i][VEC-2:0], cin[i]};
        end
        if (write_en && mode[i] == MODE_RAM && higher_order_addr == MUX_LVLS'(i)) begin
          vec_nxt[{write_lut_select, addr_a[i]}] = data_in;
        end
        chain_nxt[i*LUT_W+2 +: VEC] = vec_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain    <= '0;
      sync_out <= '0;
    end else begin
      chain <= chain_nxt;
      if (reg_ce) begin
        sync_out <= out;
      end
    end
  end

endmodule

// File: tb/tb_slicem_srl.sv
module tb_slicem_srl;
  localparam int K  = 4;
  localparam int N  = 4;
  localparam int ML = 2;
  localparam int LW = 34;
  localparam int CL = N*LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cen, config_in, config_out;
  logic [2*K*N-1:0]  luts_in;
  logic [ML-1:0]     higher_order_addr;
  logic              data_in, write_en, write_lut_select, shift_en, reg_ce;
  logic [2*N-1:0]    out, sync_out;
  logic              wide_out, srl_q;

  int total = 0;
  int bad   = 0;

  logic [CL-1:0] image;          // expected storage contents
  logic [K-1:0]  addr_a [N];
  logic [K-1:0]  addr_b [N];

  slicem_srl dut (
    .clk(clk), .rst(rst), .cen(cen), .config_in(config_in), .config_out(config_out),
    .luts_in(luts_in), .higher_order_addr(higher_order_addr), .data_in(data_in),
    .write_en(write_en), .write_lut_select(write_lut_select), .shift_en(shift_en),
    .reg_ce(reg_ce), .out(out), .wide_out(wide_out), .srl_q(srl_q), .sync_out(sync_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_addr();
    for (int i = 0; i < N; i++) begin
      luts_in[2*K*i +: K]   = addr_a[i];
      luts_in[2*K*i+K +: K] = addr_b[i];
    end
    #1;
  endtask

  task automatic set_all_addr(input int a);
    for (int i = 0; i < N; i++) begin
      addr_a[i] = K'(a);
      addr_b[i] = K'(a);
    end
    apply_addr();
  endtask

  function automatic logic [LW-1:0] lut(input logic [1:0] m, input logic [15:0] h0, input logic [15:0] h1);
    return {h1, h0, m};
  endfunction

  function automatic logic [2*N-1:0] model_out();
    logic [2*N-1:0] r;
    logic [31:0]    v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      v          = image[i*LW+2 +: 32];
      r[2*i]     = v[addr_a[i]];
      r[2*i+1]   = v[16+addr_b[i]];
    end
    return r;
  endfunction

  // Shifts img in MSB first; config_out must replay the previous contents.
  task automatic load(input logic [CL-1:0] img);
    int errs;
    errs = 0;
    for (int b = CL-1; b >= 0; b--) begin
      config_in = img[b];
      cen = 1'b1;
      tick();
      if (b > 0 && config_out !== image[b-1]) errs++;
    end
    cen = 1'b0;
    config_in = 1'b0;
    check("cfg_out_replays_prior", errs, 0);
    image = img;
    check("cfg_out_after_load", config_out, img[CL-1]);
  endtask

  task automatic sweep_model(input string tag);
    for (int a = 0; a < 16; a++) begin
      set_all_addr(a);
      check(tag, out, model_out());
    end
  endtask

  initial begin
    logic [CL-1:0]  img1, img_srl;
    logic [15:0]    a5, f0;
    logic [2*N-1:0] expo, e0, e1, e2;
    int first_tap, first_top, first_q, exp_top, exp_q;

    rst = 1'b1; cen = 1'b0; config_in = 1'b0; luts_in = '0; higher_order_addr = '0;
    data_in = 1'b0; write_en = 1'b0; write_lut_select = 1'b0; shift_en = 1'b0; reg_ce = 1'b0;
    image = '0;
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; addr_b[i] = '0; end

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_config_out", config_out, 0);
    check("rst_sync_out", sync_out, 0);
    check("rst_wide_out", wide_out, 0);
    check("rst_srl_q", srl_q, 0);

    // ROM load and sweep
    img1 = {lut(2'b00, 16'hFFFF, 16'h8000), lut(2'b01, 16'h0000, 16'h0000),
            lut(2'b00, 16'h1234, 16'h8001), lut(2'b00, 16'hA5A5, 16'h0F0F)};
    load(img1);
    a5 = 16'hA5A5;
    f0 = 16'h0F0F;
    for (int a = 0; a < 16; a++) begin
      set_all_addr(a);
      higher_order_addr = ML'(a);
      #1;
      expo = model_out();
      check("rom_lut0_h0", out[0], a5[a]);
      check("rom_lut0_h1", out[1], f0[a]);
      check("rom_out", out, expo);
      check("rom_wide", wide_out, expo[2*(a%4)]);
    end

    // RAM writes into LUT2
    addr_a[2] = 4'd5; addr_b[2] = 4'd5; apply_addr();
    higher_order_addr = 2'd2; write_lut_select = 1'b1; data_in = 1'b1; write_en = 1'b1;
    #1;
    check("ram_before_write", out[5], 0);
    tick();
    write_en = 1'b0; data_in = 1'b0;
    #1;
    check("ram_h1_5_set", out[5], 1);
    check("ram_h0_5_clear", out[4], 0);
    image[2*LW+2+16+5] = 1'b1;
    check("ram_out_model", out, model_out());

    addr_a[2] = 4'd9; apply_addr();
    write_lut_select = 1'b0; data_in = 1'b1; write_en = 1'b1;
    tick();
    write_en = 1'b0; data_in = 1'b0;
    #1;
    check("ram_h0_9_set", out[4], 1);
    image[2*LW+2+9] = 1'b1;

    addr_a[2] = 4'd5; apply_addr();
    write_lut_select = 1'b1; data_in = 1'b0; write_en = 1'b1;
    tick();
    write_en = 1'b0;
    #1;
    check("ram_h1_5_cleared", out[5], 0);
    image[2*LW+2+16+5] = 1'b0;

    // Writes aimed at ROM LUTs are dropped
    for (int i = 0; i < N; i++) begin addr_a[i] = 4'd5; addr_b[i] = 4'd5; end
    apply_addr();
    data_in = 1'b1; write_lut_select = 1'b1;
    higher_order_addr = 2'd1; write_en = 1'b1; tick();
    higher_order_addr = 2'd3; write_lut_select = 1'b0; tick();
    write_en = 1'b0; data_in = 1'b0;
    #1;
    check("rom_write_dropped_l1", out[3], 0);
    sweep_model("rom_write_dropped");

    // cen outranks write_en and shift_en
    addr_a[2] = 4'd3; apply_addr();
    higher_order_addr = 2'd2; write_lut_select = 1'b0; data_in = 1'b1;
    cen = 1'b1; config_in = 1'b1; write_en = 1'b1; shift_en = 1'b1;
    tick();
    cen = 1'b0; config_in = 1'b0; write_en = 1'b0; shift_en = 1'b0; data_in = 1'b0;
    check("prio_config_out", config_out, image[CL-2]);
    image = {image[CL-2:0], 1'b1};
    sweep_model("prio_only_chain_shift");

    // SRL: single 1 followed by zeros
    img_srl = {N{lut(2'b10, 16'h0000, 16'h0000)}};
    load(img_srl);
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; addr_b[i] = '0; end
    addr_a[0] = 4'd3;      // tap 3 of LUT0 -> delay of 4
    addr_b[3] = 4'd15;     // top bit of LUT3
    apply_addr();
    first_tap = 0; first_top = 0; first_q = 0;
    for (int k = 1; k <= 140; k++) begin
      data_in = (k == 1);
      shift_en = 1'b1;
      tick();
      if (first_tap == 0 && out[0] === 1'b1) first_tap = k;
      if (first_top == 0 && out[7] === 1'b1) first_top = k;
      if (first_q == 0 && srl_q === 1'b1) first_q = k;
    end
    shift_en = 1'b0; data_in = 1'b0;
`ifdef SLICEM_SRL_CASCADE_EN
    exp_top = 128;
    exp_q   = 128;
`else
    exp_top = 32;
    exp_q   = 0;
`endif
    check("srl_tap3_delay", first_tap, 4);
    check("srl_lut3_top", first_top, exp_top);
    check("srl_q_first_rise", first_q, exp_q);
    check("srl_q_after_pass", srl_q, 0);

    // Reset mid-load, with cen still high during the reset cycle
    cen = 1'b1; config_in = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cen = 1'b0; config_in = 1'b0;
    image = '0;
    #1;
    check("midrst_config_out", config_out, 0);
    check("midrst_sync_out", sync_out, 0);
    sweep_model("midrst_out_zero");
    for (int i = 0; i < N; i++) begin addr_a[i] = 4'd5; addr_b[i] = 4'd5; end
    apply_addr();
    higher_order_addr = 2'd2; write_lut_select = 1'b1; data_in = 1'b1;
    write_en = 1'b1; shift_en = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    write_en = 1'b0; shift_en = 1'b0; data_in = 1'b0;
    #1;
    check("midrst_modes_rom", out, 0);
    check("midrst_srl_q", srl_q, 0);

    // sync_out capture and hold
    load(img1);
    set_all_addr(0); e0 = model_out();
    reg_ce = 1'b1;
    tick();
    check("sync_capture0", sync_out, e0);
    reg_ce = 1'b0;
    set_all_addr(1); e1 = model_out();
    check("sync_out_now", out, e1);
    check("sync_lags_out", sync_out, e0);
    tick();
    check("sync_holds", sync_out, e0);
    reg_ce = 1'b1;
    tick();
    check("sync_capture1", sync_out, e1);
    set_all_addr(2); e2 = model_out();
    check("sync_before_edge", sync_out, e1);
    tick();
    check("sync_capture2", sync_out, e2);
    reg_ce = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
